multi_pb_debouncer: RTL and testbench
=====================================

Name: multi_pb_debouncer

Overview:
- Parametrised NUM_PB-channel push-button debouncer and pulse generator for the board UI layer.
- Sits between the raw button pins and the game/control FSMs.
- Per channel it produces:
  - DPB: debounced level.
  - SCEN: single clock enable, one per press.
  - MCEN: multiple clock enable, an auto-repeat burst, then continuous while held.
  - CCEN: continuous clock enable while held.
- New over the single-button generation:
  - Release pulse per channel.
  - Configurable timing and burst length.
  - Aggregated "any press" event with a priority-encoded channel index.

Parameters:
- NUM_PB, 5, number of independent button channels (1..16).
- N_DC, 25, debounce counter width; T_SHORT = 2^(N_DC-2) cycles, T_LONG = 2^(N_DC-1) cycles.
- MCEN_BURST, 8, number of MCEN pulses (SCEN pulse included) before MCEN goes continuous (2..15).
- IDX_W, $clog2(NUM_PB) (min 1), width of scen_idx.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pb  in  NUM_PB  raw button inputs, active-high.
- dpb  out  NUM_PB  debounced level per channel.
- scen  out  NUM_PB  one-cycle pulse per accepted press.
- mcen  out  NUM_PB  burst/continuous repeat enable.
- ccen  out  NUM_PB  continuous enable while held.
- rel  out  NUM_PB  one-cycle pulse on confirmed release.
- scen_any  out  1  OR of scen, registered in the same cycle as scen.
- scen_idx  out  IDX_W  lowest-numbered channel with scen high; 0 when scen_any=0.

Behaviour:
- Reset (async): every channel goes to INI, counters are cleared to 0 (never X), and all outputs are 0.
- Reset mid-press: the channel returns to INI. After reset deasserts, the press must re-qualify through WQ.
- Channels are fully independent, one FSM per channel. All outputs decode directly from state bits (registered, glitch-free).

State outputs, in the order DPB/SCEN/MCEN/CCEN/REL:
- INI 00000
- WQ 00000
- SCEN_ST 11110
- WH 10000
- MCEN_ST 10110
- CCEN_ST 10010
- MCEN_CONT 10110
- CCR 10000
- WFCR 10000
- REL_ST 00001

Transitions (cnt = per-channel N_DC-bit counter; mc = burst counter):
- INI: cnt<=0, mc<=0. pb=1 -> WQ.
- WQ: cnt++. pb=0 -> INI. cnt[N_DC-2]=1 -> SCEN_ST. Press-to-SCEN latency is T_SHORT+1 cycles after the edge that first samples pb=1.
- SCEN_ST (1 cycle): cnt<=0, mc++, -> WH.
- WH: cnt++. pb=0 -> CCR. cnt[N_DC-1]=1 -> MCEN_ST.
- MCEN_ST (1 cycle): cnt<=0, mc++, -> CCEN_ST.
- CCEN_ST: cnt++. pb=0 -> CCR. cnt[N_DC-2]=1 -> MCEN_CONT if mc==MCEN_BURST, else MCEN_ST.
- MCEN_CONT: hold until pb=0 -> CCR.
- CCR (1 cycle): cnt<=0, mc<=0, -> WFCR.
- WFCR: cnt++. pb=1 -> WH (a bounce is treated as a continued hold; no new SCEN). cnt[N_DC-2]=1 -> REL_ST.
- REL_ST (1 cycle): -> INI.

Boundary rules:
- pb release and timer expiry in the same cycle: release wins.
- mc saturates and never wraps.
- cnt cannot wrap, because every counting state exits at the tested bit.
- Simultaneous SCEN on several channels: all scen bits are set, scen_any=1, and scen_idx reports the lowest index.

Optional Feature:
- Macro: MULTI_PB_SYNC_EN.
- Defined: each pb bit passes through a 2-flop synchroniser, reset to 0, before its FSM. All latencies grow by 2 cycles.
- Undefined: pb feeds the FSMs directly; the caller guarantees synchronous inputs.

Decomposition:
- Package debounce_pkg holds:
  - the state localparams with their 10-bit encodings (5 output bits + 5 bits that make states unique);
  - the T_SHORT/T_LONG bit-index helper functions.
- Sub-module debounce_chan: a single-channel FSM with its counters, instantiated NUM_PB times in a generate loop.
- The top level holds only the optional synchroniser, the scen_any OR, and the priority encoder.

Test Plan:
All scenarios use NUM_PB=4, N_DC=6 (T_SHORT=16, T_LONG=32), MCEN_BURST=4.
- Clean press ch0, held 10 cycles then released:
  - Never reaches SCEN; dpb stays 0.
  - rel stays 0.
- Press ch1, held 200 cycles:
  - scen[1] pulses once, 17 cycles after the sampling edge.
  - mcen[1] pulses 3 more times, spaced by the WH and CCEN_ST waits.
  - mcen[1] is then continuous; ccen[1] is high throughout.
  - On release, rel[1] pulses 18 cycles later and dpb[1] falls in the same cycle.
- Release bounce ch2: after SCEN, pb low for 5 cycles then high again:
  - Goes CCR -> WFCR -> WH with no second scen.
  - dpb[2] stays 1.
- Simultaneous press ch3 and ch1, same edge:
  - scen[1] and scen[3] are high in the same cycle.
  - scen_any=1, scen_idx=1.
- Async reset asserted while ch0 is in MCEN_CONT:
  - All outputs are 0 immediately.
  - After deassert with pb still held, the next scen[0] comes 17 cycles after the first sampling edge.
- Build with MULTI_PB_SYNC_EN: repeat the ch1 hold; scen latency becomes 19 cycles.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// the counter bit-index helpers used to derive T_SHORT / T_LONG.
// Latency: n/a (package). Backpressure: n/a.
//
// Each state is 10 bits wide. The upper 5 bits are the channel outputs in the
// order DPB/SCEN/MCEN/CCEN/REL, so outputs are plain wires off the state flops.
// The lower 5 bits only make states with equal outputs distinct.
package debounce_pkg;

  // Burst counter width; MCEN_BURST is limited to 2..15 so 4 bits suffice.
  localparam int MC_W = 4;

  // Bit positions of the outputs inside the state vector.
  localparam int OB_DPB  = 9;
  localparam int OB_SCEN = 8;
  localparam int OB_MCEN = 7;
  localparam int OB_CCEN = 6;
  localparam int OB_REL  = 5;

  typedef enum logic [9:0] {
    ST_INI       = 10'b00000_00000,
    ST_WQ        = 10'b00000_00001,
    ST_SCEN      = 10'b11110_00010,
    ST_WH        = 10'b10000_00011,
    ST_MCEN      = 10'b10110_00100,
    ST_CCEN      = 10'b10010_00101,
    ST_MCEN_CONT = 10'b10110_00110,
    ST_CCR       = 10'b10000_00111,
    ST_WFCR      = 10'b10000_01000,
    ST_REL       = 10'b00001_01001
  } state_t;

  // Counter bit that becomes set after T_SHORT = 2^(N_DC-2) increments.
  function automatic int t_short_bit(input int n_dc);
    return n_dc - 2;
  endfunction

  // Counter bit that becomes set after T_LONG = 2^(N_DC-1) increments.
  function automatic int t_long_bit(input int n_dc);
    return n_dc - 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single-channel push-button debouncer FSM with qualify/hold timer and burst counter.
// Latency: press-to-scen T_SHORT+1 cycles, release-to-rel T_SHORT+2 cycles.
// Backpressure: none; free-running, outputs are registered state bits.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   pb           synchronous raw button level
//   dpb          debounced level
//   scen         one-cycle pulse per accepted press
//   mcen         auto-repeat burst, then continuous while held
//   ccen         continuous enable while held (past the first hold period)
//   rel          one-cycle pulse on confirmed release
//   scen_nxt     value scen will take after the next clock edge, so the
//                top level can register scen_any/scen_idx aligned with scen
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int N_DC       = 25,
  parameter int MCEN_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen,
  output logic rel,
  output logic scen_nxt
);

  localparam int TS = t_short_bit(N_DC);
  localparam int TL = t_long_bit(N_DC);
  localparam logic [MC_W-1:0] BURST = MC_W'(MCEN_BURST);

  state_t            state;
  logic [N_DC-1:0]   cnt;
  logic [MC_W-1:0]   mc;

  // Burst counter saturates rather than wraps.
  function automatic logic [MC_W-1:0] mc_inc(input logic [MC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Every counting state leaves as soon as its tested bit is set, so cnt
  // never reaches its maximum. A release always takes priority over an
  // expiring timer in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INI;
      cnt   <= '0;
      mc    <= '0;
    end else begin
      unique case (state)
        ST_INI: begin
          cnt <= '0;
          mc  <= '0;
          if (pb) state <= ST_WQ;
        end

        ST_WQ: begin
          cnt <= cnt + 1'b1;
          if (!pb)         state <= ST_INI;
          else if (cnt[TS]) state <= ST_SCEN;
        end

        ST_SCEN: begin
          cnt   <= '0;
          mc    <= mc_inc(mc);
          state <= ST_WH;
        end

        ST_WH: begin
          cnt <= cnt + 1'b1;
          if (!pb)          state <= ST_CCR;
          else if (cnt[TL]) state <= ST_MCEN;
        end

        ST_MCEN: begin
          cnt   <= '0;
          mc    <= mc_inc(mc);
          state <= ST_CCEN;
        end

        ST_CCEN: begin
          cnt <= cnt + 1'b1;
          if (!pb)          state <= ST_CCR;
          else if (cnt[TS]) state <= (mc == BURST) ? ST_MCEN_CONT : ST_MCEN;
        end

        ST_MCEN_CONT: begin
          if (!pb) state <= ST_CCR;
        end

        ST_CCR: begin
          cnt   <= '0;
          mc    <= '0;
          state <= ST_WFCR;
        end

        // A level bounce during release qualification resumes the hold
        // without producing a fresh scen.
        ST_WFCR: begin
          cnt <= cnt + 1'b1;
          if (pb)           state <= ST_WH;
          else if (cnt[TS]) state <= ST_REL;
        end

        ST_REL: begin
          state <= ST_INI;
        end

        default: begin
          state <= ST_INI;
          cnt   <= '0;
          mc    <= '0;
        end
      endcase
    end
  end

  assign dpb  = state[OB_DPB];
  assign scen = state[OB_SCEN];
  assign mcen = state[OB_MCEN];
  assign ccen = state[OB_CCEN];
  assign rel  = state[OB_REL];

  // Only WQ with a held button and an expired short timer enters SCEN_ST.
  assign scen_nxt = (state == ST_WQ) && pb && cnt[TS];

endmodule

// File: rtl/multi_pb_debouncer.sv
// NUM_PB-channel push-button debouncer with aggregated press event and priority index.
// Latency: press-to-scen T_SHORT+1 cycles (+2 with MULTI_PB_SYNC_EN defined).
// Backpressure: none; all outputs are registered and free-running.
//
// Optional build macro: MULTI_PB_SYNC_EN adds a 2-flop synchroniser per pb bit.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   pb           raw button inputs, active-high
//   dpb          debounced level per channel
//   scen         one-cycle pulse per accepted press
//   mcen         burst/continuous repeat enable
//   ccen         continuous enable while held
//   rel          one-cycle pulse on confirmed release
//   scen_any     OR of scen, aligned with scen
//   scen_idx     lowest channel with scen high, 0 when scen_any is 0
module multi_pb_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_PB     = 5,
  parameter int N_DC       = 25,
  parameter int MCEN_BURST = 8,
  parameter int IDX_W      = (NUM_PB > 1) ? $clog2(NUM_PB) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] dpb,
  output logic [NUM_PB-1:0] scen,
  output logic [NUM_PB-1:0] mcen,
  output logic [NUM_PB-1:0] ccen,
  output logic [NUM_PB-1:0] rel,
  output logic              scen_any,
  output logic [IDX_W-1:0]  scen_idx
);

  logic [NUM_PB-1:0] pb_s;
  logic [NUM_PB-1:0] scen_nxt;
  logic [IDX_W-1:0]  idx_nxt;

`ifdef MULTI_PB_SYNC_EN
  logic [NUM_PB-1:0] sync_q1;
  logic [NUM_PB-1:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pb;
      sync_q2 <= sync_q1;
    end
  end

  assign pb_s = sync_q2;
`else
  assign pb_s = pb;
`endif

  for (genvar g = 0; g < NUM_PB; g++) begin : g_chan
    debounce_chan #(
      .N_DC       (N_DC),
      .MCEN_BURST (MCEN_BURST)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .pb       (pb_s[g]),
      .dpb      (dpb[g]),
      .scen     (scen[g]),
      .mcen     (mcen[g]),
      .ccen     (ccen[g]),
      .rel      (rel[g]),
      .scen_nxt (scen_nxt[g])
    );
  end

  // Scan from the top down so the lowest active channel wins.
  always_comb begin
    idx_nxt = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (scen_nxt[i]) idx_nxt = IDX_W'(i);
    end
  end

  // Registered from the channels' next-state scen so these land in the
  // same cycle as the scen flops themselves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scen_any <= 1'b0;
      scen_idx <= '0;
    end else begin
      scen_any <= |scen_nxt;
      scen_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_multi_pb_debouncer.sv
module tb_multi_pb_debouncer;

  localparam int NUM_PB = 4;
`ifdef MULTI_PB_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pb = 4'b0;
  logic [3:0] dpb, scen, mcen, ccen, rel;
  logic       scen_any;
  logic [1:0] scen_idx;

  int n_pass = 0;
  int n_total = 0;

  multi_pb_debouncer #(
    .NUM_PB     (NUM_PB),
    .N_DC       (6),
    .MCEN_BURST (4),
    .IDX_W      (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pb       (pb),
    .dpb      (dpb),
    .scen     (scen),
    .mcen     (mcen),
    .ccen     (ccen),
    .rel      (rel),
    .scen_any (scen_any),
    .scen_idx (scen_idx)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pb = 4'b0;
    tick(2);
    n_total++; if (dpb !== 4'b0) $display("FAIL reset_dpb: got %b want 0000", dpb); else n_pass++;
    n_total++; if (scen !== 4'b0) $display("FAIL reset_scen: got %b want 0000", scen); else n_pass++;
    n_total++; if (mcen !== 4'b0) $display("FAIL reset_mcen: got %b want 0000", mcen); else n_pass++;
    n_total++; if (ccen !== 4'b0) $display("FAIL reset_ccen: got %b want 0000", ccen); else n_pass++;
    n_total++; if (rel !== 4'b0) $display("FAIL reset_rel: got %b want 0000", rel); else n_pass++;
    n_total++; if (scen_any !== 1'b0) $display("FAIL reset_scen_any: got %b want 0", scen_any); else n_pass++;
    n_total++; if (scen_idx !== 2'd0) $display("FAIL reset_scen_idx: got %0d want 0", scen_idx); else n_pass++;
    reset = 1'b0;
    tick(2);
  endtask

  // Press shorter than T_SHORT never qualifies.
  task automatic test_short_press;
    logic seen_dpb, seen_scen, seen_rel;
    seen_dpb = 1'b0; seen_scen = 1'b0; seen_rel = 1'b0;
    pb[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen_dpb |= dpb[0]; seen_scen |= scen[0]; seen_rel |= rel[0];
    end
    pb[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen_dpb |= dpb[0]; seen_scen |= scen[0]; seen_rel |= rel[0];
    end
    n_total++; if (seen_dpb !== 1'b0) $display("FAIL short_dpb: got %b want 0", seen_dpb); else n_pass++;
    n_total++; if (seen_scen !== 1'b0) $display("FAIL short_scen: got %b want 0", seen_scen); else n_pass++;
    n_total++; if (seen_rel !== 1'b0) $display("FAIL short_rel: got %b want 0", seen_rel); else n_pass++;
  endtask

  // Hold ch1 for 200 cycles, then release.
  task automatic test_hold;
    logic [199:0] sc_log, mc_log, cc_log, dp_log;
    logic [24:0]  rl_log, rd_log;
    int bad_sc, bad_mc, bad_cc, bad_dp, bad_rl, bad_rd;
    logic exp_sc, exp_mc, exp_cc, exp_dp;
    bad_sc = 0; bad_mc = 0; bad_cc = 0; bad_dp = 0; bad_rl = 0; bad_rd = 0;
    pb[1] = 1'b1;
    // e = index of the edge just passed, counting the first sampling edge as 0
    for (int e = 0; e < 200; e++) begin
      tick(1);
      sc_log[e] = scen[1]; mc_log[e] = mcen[1]; cc_log[e] = ccen[1]; dp_log[e] = dpb[1];
    end
    for (int e = 0; e < 200; e++) begin
      exp_sc = (e == 17 + L);
      exp_mc = (e == 17 + L) || (e == 51 + L) || (e == 69 + L) || (e == 87 + L) || (e >= 105 + L);
      exp_cc = (e == 17 + L) || (e >= 51 + L);
      exp_dp = (e >= 17 + L);
      if (sc_log[e] !== exp_sc) bad_sc++;
      if (mc_log[e] !== exp_mc) bad_mc++;
      if (cc_log[e] !== exp_cc) bad_cc++;
      if (dp_log[e] !== exp_dp) bad_dp++;
    end
    n_total++; if (sc_log[17+L] !== 1'b1) $display("FAIL hold_scen_latency: got %b want 1 at edge %0d", sc_log[17+L], 17 + L); else n_pass++;
    n_total++; if (bad_sc != 0) $display("FAIL hold_scen_timeline: got %0d wrong cycles want 0", bad_sc); else n_pass++;
    n_total++; if (bad_mc != 0) $display("FAIL hold_mcen_timeline: got %0d wrong cycles want 0", bad_mc); else n_pass++;
    n_total++; if (bad_cc != 0) $display("FAIL hold_ccen_timeline: got %0d wrong cycles want 0", bad_cc); else n_pass++;
    n_total++; if (bad_dp != 0) $display("FAIL hold_dpb_timeline: got %0d wrong cycles want 0", bad_dp); else n_pass++;

    pb[1] = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      rl_log[c-1] = rel[1]; rd_log[c-1] = dpb[1];
    end
    for (int c = 1; c <= 25; c++) begin
      if (rl_log[c-1] !== (c == 19 + L)) bad_rl++;
      if (rd_log[c-1] !== (c < 19 + L)) bad_rd++;
    end
    n_total++; if (rl_log[18+L] !== 1'b1) $display("FAIL release_rel_latency: got %b want 1 at cycle %0d", rl_log[18+L], 19 + L); else n_pass++;
    n_total++; if (bad_rl != 0) $display("FAIL release_rel_timeline: got %0d wrong cycles want 0", bad_rl); else n_pass++;
    n_total++; if (bad_rd != 0) $display("FAIL release_dpb_timeline: got %0d wrong cycles want 0", bad_rd); else n_pass++;
  endtask

  // Short low glitch after the press returns to hold without a second scen.
  task automatic test_bounce;
    int n_scen, n_rel;
    logic dpb_dropped;
    n_scen = 0; n_rel = 0; dpb_dropped = 1'b0;
    pb[2] = 1'b1;
    tick(18 + L);
    n_total++; if (scen[2] !== 1'b1) $display("FAIL bounce_first_scen: got %b want 1", scen[2]); else n_pass++;
    pb[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (scen[2]) n_scen++;
      if (rel[2]) n_rel++;
      if (!dpb[2]) dpb_dropped = 1'b1;
    end
    pb[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (scen[2]) n_scen++;
      if (rel[2]) n_rel++;
      if (!dpb[2]) dpb_dropped = 1'b1;
    end
    n_total++; if (n_scen != 0) $display("FAIL bounce_no_rescen: got %0d pulses want 0", n_scen); else n_pass++;
    n_total++; if (dpb_dropped !== 1'b0) $display("FAIL bounce_dpb_held: got drop=%b want 0", dpb_dropped); else n_pass++;
    pb[2] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rel[2]) n_rel++;
    end
    n_total++; if (n_rel != 1) $display("FAIL bounce_single_rel: got %0d pulses want 1", n_rel); else n_pass++;
  endtask

  // ch1 and ch3 pressed on the same edge.
  task automatic test_simultaneous;
    pb = 4'b1010;
    tick(17 + L);
    n_total++; if (scen_any !== 1'b0) $display("FAIL simul_pre_scen_any: got %b want 0", scen_any); else n_pass++;
    tick(1);
    n_total++; if (scen !== 4'b1010) $display("FAIL simul_scen: got %b want 1010", scen); else n_pass++;
    n_total++; if (scen_any !== 1'b1) $display("FAIL simul_scen_any: got %b want 1", scen_any); else n_pass++;
    n_total++; if (scen_idx !== 2'd1) $display("FAIL simul_scen_idx: got %0d want 1", scen_idx); else n_pass++;
    tick(1);
    n_total++; if (scen_any !== 1'b0) $display("FAIL simul_post_scen_any: got %b want 0", scen_any); else n_pass++;
    n_total++; if (scen_idx !== 2'd0) $display("FAIL simul_post_scen_idx: got %0d want 0", scen_idx); else n_pass++;
    pb = 4'b0;
    tick(40);
  endtask

  // Async reset while ch0 is in continuous repeat, then re-qualify.
  task automatic test_reset_mid;
    pb[0] = 1'b1;
    tick(120 + L);
    n_total++; if ({mcen[0], ccen[0]} !== 2'b11) $display("FAIL mid_precond_mcen_ccen: got %b want 11", {mcen[0], ccen[0]}); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({dpb, scen, mcen, ccen, rel, scen_any, scen_idx} !== 23'd0)
      $display("FAIL mid_reset_outputs: got %h want 0", {dpb, scen, mcen, ccen, rel, scen_any, scen_idx});
    else n_pass++;
    tick(2);
    reset = 1'b0;
    tick(17 + L);
    n_total++; if (scen[0] !== 1'b0) $display("FAIL mid_scen_early: got %b want 0", scen[0]); else n_pass++;
    tick(1);
    n_total++; if (scen[0] !== 1'b1) $display("FAIL mid_scen_requal: got %b want 1", scen[0]); else n_pass++;
    pb[0] = 1'b0;
    tick(60);
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_hold();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
